alu_rr_arbiter: RTL and testbench
=================================

# alu_rr_arbiter

Shares one W-bit ALU (add, subtract, AND, OR, zero flag) between two requesters. Each requester has a valid/ready operand port. A round-robin arbiter grants one requester per cycle. The result is registered into a single-entry output buffer and returned with the requester ID over a valid/ready response port. The block sits between the two operand sources and the shared arithmetic datapath.

## Interface
- W, default 4, operand and result width
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  W  requester 0 operands
- req0_op  input  2  requester 0 opcode: 00 add, 01 sub, 10 AND, 11 OR
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as req0, for requester 1
- rsp_valid  output  1  response buffer holds a result
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  1  requester that issued the operation
- rsp_result  output  W  ALU result
- rsp_zero  output  1  high when rsp_result is all zeros

## Operation
- Two-state FSM tracks the output buffer:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on rsp_valid && rsp_ready with no new accept.
  - FULL → FULL on drain plus accept in the same cycle.
- can_accept = (state == EMPTY) || rsp_ready.
- Grant is combinational from req*_valid, can_accept and the rr_last register:
  - Only one requester valid: that one is granted.
  - Both valid: grant the requester that is not rr_last.
- reqX_ready = grant to X. This depends on rsp_ready through can_accept; req*_valid must not depend on ready.
- On accept:
  - Buffer loads {id, op(a,b), zero}.
  - rr_last ← granted id.
- rr_last is unchanged when nothing is accepted.
- Arithmetic is modulo 2^W:
  - Add discards the carry.
  - Sub is a − b in two's complement, wrapping (e.g. 1 − 2 = 4'hF).
  - No carry or overflow outputs.
- rsp_zero is computed from the same result written to the buffer, never from the live operands.
- Response outputs are stable while rsp_valid && !rsp_ready.
- Reset (asserted at any time, including mid-transfer):
  - state EMPTY, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0.
  - rr_last 1, so requester 0 wins the first contention.
  - In-flight results are discarded.
  - req*_ready is 0 while rst_n is low.

## Timing
- Latency: accept at edge N → rsp_valid high after edge N.
- Throughput: one operation per cycle while rsp_ready stays high.
- With rsp_ready low and the buffer FULL, both req*_ready are 0 (back-pressure).
- Simultaneous drain and accept at the same edge loads the new result without a bubble cycle.
- No combinational path from req* operands to rsp_* outputs; all rsp_* are register outputs.

## Configuration
- ALU_RR_FIXED_PRIO_EN
  - Defined: fixed priority. Requester 0 always wins contention, rr_last is not used, and requester 1 can starve.
  - Undefined (default): round-robin as above.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - Buffer state encoding ST_EMPTY/ST_FULL.
- One sub-module, alu_core: purely combinational, inputs a, b, op, outputs result and zero, parameterised by W. Instantiated once after the operand mux.

## Test plan
- Reset, then req0 add a=4'h7 b=4'h9, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=4'h0, rsp_zero=1.
- req1 sub a=4'h1 b=4'h2 → rsp_result=4'hF, rsp_zero=0, rsp_id=1. Then AND 4'hC,4'hA → 4'h8; OR 4'hC,4'hA → 4'hE.
- Both valid continuously, rsp_ready=1 → response IDs alternate 0,1,0,1 starting with 0. With ALU_RR_FIXED_PRIO_EN → IDs all 0 and req1_ready never high.
- Buffer FULL, rsp_ready=0 for 3 cycles → rsp_* constant, req*_ready=0. Then raise rsp_ready with req0 valid → same edge drains and loads, rsp_valid stays 1.
- Back-to-back stream of 8 ops, rsp_ready=1 → 8 responses in 8 consecutive cycles, none lost or duplicated.
- rst_n pulsed low asynchronously mid-cycle while FULL → rsp_valid drops immediately with no clock edge. After release, the first contention grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU arbiter.
//   - OP_* : 2-bit opcode encodings understood by alu_core
//   - buf_state_t : occupancy encoding of the single-entry response buffer
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// alu_core: purely combinational W-bit ALU.
// Ports:
//   a, b    : operands (W bits)
//   op      : opcode, see alu_pkg OP_* (add, sub, and, or)
//   result  : op(a, b) modulo 2^W, carry/borrow discarded
//   zero    : high when result is all zeros
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] result,
  output logic         zero
);

  // Operation select; W-bit arithmetic wraps naturally.
  always_comb begin
    result = {W{1'b0}};
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = {W{1'b0}};
    endcase
  end

  assign zero = (result == {W{1'b0}});

endmodule : alu_core

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: two requesters share one W-bit ALU through a round-robin
// arbiter; results go into a single-entry registered response buffer.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid/reqN_ready      : operand handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_op    : operands and opcode for requester N
//   rsp_valid/rsp_ready        : response handshake
//   rsp_id, rsp_result, rsp_zero : registered response payload
// Build option:
//   ALU_RR_FIXED_PRIO_EN : when defined, requester 0 always wins contention
//                          (no round-robin state; requester 1 may starve).
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero
);

  buf_state_t   state_r;
`ifndef ALU_RR_FIXED_PRIO_EN
  logic         rr_last_r;
`endif
  logic         can_accept_s;
  logic         grant0_s;
  logic         grant1_s;
  logic         accept_s;
  logic [W-1:0] sel_a_s;
  logic [W-1:0] sel_b_s;
  logic [1:0]   sel_op_s;
  logic [W-1:0] alu_result_s;
  logic         alu_zero_s;

  // A slot is free when the buffer is empty or is being drained this edge.
  assign can_accept_s = (state_r == ST_EMPTY) || rsp_ready;

  // Grant logic; rst_n gating keeps both readys low throughout reset.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst_n && can_accept_s) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_RR_FIXED_PRIO_EN
        grant0_s = 1'b1;
`else
        if (rr_last_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
`endif
      end else if (req0_valid) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign accept_s   = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Operand mux in front of the single shared ALU.
  assign sel_a_s  = grant1_s ? req1_a  : req0_a;
  assign sel_b_s  = grant1_s ? req1_b  : req0_b;
  assign sel_op_s = grant1_s ? req1_op : req0_op;

  alu_core #(.W(W)) u_alu_core (
    .a      (sel_a_s),
    .b      (sel_b_s),
    .op     (sel_op_s),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  // Buffer FSM with registered response outputs; a drain and an accept at
  // the same edge simply reload the buffer, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_EMPTY;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= {W{1'b0}};
      rsp_zero   <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r   <= ST_FULL;
            rsp_valid <= 1'b1;
          end else begin
            state_r   <= ST_EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (accept_s) begin
            state_r   <= ST_FULL;
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            state_r   <= ST_EMPTY;
            rsp_valid <= 1'b0;
          end else begin
            state_r   <= ST_FULL;
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
      if (accept_s) begin
        rsp_id     <= grant1_s;
        rsp_result <= alu_result_s;
        rsp_zero   <= alu_zero_s;
      end
    end
  end

`ifndef ALU_RR_FIXED_PRIO_EN
  // Round-robin pointer: remembers the last granted requester; resets to 1
  // so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= 1'b1;
    end else if (accept_s) begin
      rr_last_r <= grant1_s;
    end
  end
`endif

endmodule : alu_rr_arbiter

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter: directed and random stimulus, expected
// responses queued by a reference model, compared by an independent monitor.
module tb_alu_rr_arbiter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [W-1:0] rsp_result;

  alu_rr_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int res;
    int zero;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // reference model state
  int   full_m = 0;
  int   last_m = 1;

  // monitor stall-tracking state
  int   stall_seen = 0;
  int   sv_id, sv_res, sv_zero;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int alu_ref(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % MOD;
      1:       return (a - b + MOD) % MOD;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  // One cycle of stimulus plus model prediction for the coming edge.
  task automatic drive(input int v0, input int a0, input int b0, input int op0,
                       input int v1, input int a1, input int b1, input int op1,
                       input int rr);
    int can, g0, g1;
    @(posedge clk);
    #2;
    req0_valid = v0[0]; req0_a = a0[W-1:0]; req0_b = b0[W-1:0]; req0_op = op0[1:0];
    req1_valid = v1[0]; req1_a = a1[W-1:0]; req1_b = b1[W-1:0]; req1_op = op1[1:0];
    rsp_ready  = rr[0];
    #1;
    chk("rsp_valid", rsp_valid, full_m);
    can = (full_m == 0 || rr != 0) ? 1 : 0;
    g0 = 0;
    g1 = 0;
    if (can != 0) begin
      if (v0 != 0 && v1 != 0) begin
`ifdef ALU_RR_FIXED_PRIO_EN
        g0 = 1;
`else
        if (last_m == 1) g0 = 1;
        else g1 = 1;
`endif
      end else if (v0 != 0) g0 = 1;
      else if (v1 != 0) g1 = 1;
    end
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    if (g0 != 0 || g1 != 0) begin
      exp_t e;
      e.id   = g1;
      e.res  = (g1 != 0) ? alu_ref(a1, b1, op1) : alu_ref(a0, b0, op0);
      e.zero = (e.res == 0) ? 1 : 0;
      exp_q.push_back(e);
      last_m = g1;
      full_m = 1;
    end else if (rr != 0) begin
      full_m = 0;
    end
  endtask

  // Monitor: at each falling edge, a handshake pending for the next rising
  // edge pops one expected response; a stall must keep outputs frozen.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_seen != 0) begin
          chk("stall_valid", rsp_valid, 1);
          chk("stall_id", rsp_id, sv_id);
          chk("stall_result", rsp_result, sv_res);
          chk("stall_zero", rsp_zero, sv_zero);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_zero", rsp_zero, e.zero);
          end
        end
        stall_seen = (rsp_valid && !rsp_ready) ? 1 : 0;
        sv_id   = rsp_id;
        sv_res  = rsp_result;
        sv_zero = rsp_zero;
      end else begin
        stall_seen = 0;
      end
    end
  end

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    stall_seen = 0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    exp_q.delete();
    full_m = 0;
    last_m = 1;
    #11;
    chk("rst_hold_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
    rsp_ready = 1'b0;
    #1;
    chk("init_valid", rsp_valid, 0);
    chk("init_result", rsp_result, 0);
    chk("init_ready0", req0_ready, 0);
    #11;
    rst_n = 1'b1;

    // Basic operations
    drive(1, 7, 9, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1, 2, 1, 1);
    drive(1, 12, 10, 2, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 12, 10, 3, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Contention: both valid continuously
    for (int i = 0; i < 6; i++) drive(1, i, 3, 0, 1, i, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Back-pressure, then drain+load at the same edge
    drive(1, 5, 5, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 2, 3, 0, 1, 4, 4, 3, 0);
    drive(1, 2, 3, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Back-to-back stream of 8 ops
    for (int i = 0; i < 8; i++) drive(1, i * 3, 15 - i, i % 4, 0, 0, 0, 0, 1);

    // Reset while FULL, then first contention must go to requester 0
    drive(1, 9, 9, 1, 0, 0, 0, 0, 0);
    pulse_reset();
    drive(1, 1, 1, 0, 1, 2, 2, 0, 1);
    drive(1, 3, 1, 1, 1, 6, 3, 2, 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 99) < 60) ? 1 : 0, $urandom_range(0, MOD - 1),
            $urandom_range(0, MOD - 1), $urandom_range(0, 3),
            ($urandom_range(0, 99) < 60) ? 1 : 0, $urandom_range(0, MOD - 1),
            $urandom_range(0, MOD - 1), $urandom_range(0, 3),
            ($urandom_range(0, 99) < 70) ? 1 : 0);
    end

    // Drain and confirm nothing is left outstanding
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_rr_arbiter
